// File: rtl/cla_seq_adder.sv
// Sequential wide adder: NBIT operands are added CHUNK bits per cycle,
// LSB slice first, on a single narrow adder_block with the carry held in a
// register between slices. Valid/ready handshakes on operand and result sides.
//
// Optional feature macro: CLA_SEQ_SUB_EN
//   defined   : in_sub=1 at accept computes a-b (b inverted, initial carry 1)
//   undefined : in_sub is ignored, always a+b, no inverter logic

// Narrow adder: generate/propagate carry chain, small enough to flatten.
module adder_block #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Carry for each bit position from generate/propagate terms.
  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s_o    = p ^ c[W-1:0];
  assign cout_o = c[W];

endmodule

// State table
//   state  | meaning
//   S_IDLE | waiting for operands, in_ready high
//   S_RUN  | adding slice idx_q, carry_q feeds the next slice
//   S_DONE | result presented, waiting for out_ready
module cla_seq_adder #(
  parameter int NBIT  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] in_a,
  input  logic [NBIT-1:0] in_b,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] out_s,
  output logic            out_cout,
  output logic            busy
);

  localparam int NCHUNK = NBIT / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject slice widths that do not tile the operand exactly.
  if ((CHUNK < 1) || (CHUNK > NBIT) || ((NBIT % CHUNK) != 0)) begin : g_bad_param
    $error("cla_seq_adder: NBIT must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [NBIT-1:0] a_q, a_d;
  logic [NBIT-1:0] b_q, b_d;
  logic [NBIT-1:0] s_q, s_d;
  logic            cout_q, cout_d;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] sum_sl;
  logic             blk_cout;
  logic             last_slice;

  logic             sub_go;
  logic [NBIT-1:0]  b_in;

`ifdef CLA_SEQ_SUB_EN
  assign sub_go = in_sub;
  assign b_in   = in_sub ? ~in_b : in_b;
`else
  logic unused_in_sub;
  assign unused_in_sub = in_sub;
  assign sub_go        = 1'b0;
  assign b_in          = in_b;
`endif

  // Select the operand slices addressed by the current index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IW'(k)) begin
        a_sl = a_q[k*CHUNK +: CHUNK];
        b_sl = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  adder_block #(.W(CHUNK)) u_adder (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .s_o    (sum_sl),
    .cout_o (blk_cout)
  );

  assign last_slice = (idx_q == IW'(NCHUNK - 1));

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = b_in;
          carry_d = sub_go;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IW'(k)) begin
            s_d[k*CHUNK +: CHUNK] = sum_sl;
          end
        end
        carry_d = blk_cout;
        if (last_slice) begin
          cout_d  = blk_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_s     = s_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: three instances (CHUNK = 1, 8, 32) share operand
// inputs and each has its own result handshake. Results are compared with a
// plain-arithmetic model of a+b (or a-b when CLA_SEQ_SUB_EN is defined).
module tb_cla_seq_adder;

  localparam int NBIT = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [NBIT-1:0] in_a;
  logic [NBIT-1:0] in_b;
  logic            in_sub;

  logic            ir   [3];
  logic            ov   [3];
  logic            ordy [3];
  logic [NBIT-1:0] s_o  [3];
  logic            co   [3];
  logic            bz   [3];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
    cla_seq_adder #(.NBIT(NBIT), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_s     (s_o[g]),
      .out_cout  (co[g]),
      .busy      (bz[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nch(input int d);
    return (d == 0) ? 32 : ((d == 1) ? 4 : 1);
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] s, output logic c);
    longint unsigned full;
`ifdef CLA_SEQ_SUB_EN
    if (sub) begin
      s = a - b;
      c = (a >= b);
      return;
    end
`endif
    full = longint'(a) + longint'(b);
    s = full[31:0];
    c = full[32];
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // One operation through all three instances with random result stalls.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input int smax);
    logic [31:0] es;
    logic        ec;
    bit          seen [3];
    bit          done [3];
    int          stall[3];
    int          c;
    model(a, b, sub, es, ec);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ready_before_accept", i, 64'(ir[i]), 64'd1);
      stall[i] = int'($urandom_range(smax, 0));
      seen[i]  = 1'b0;
      done[i]  = 1'b0;
      ordy[i]  = 1'b0;
    end
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = $urandom;
    in_sub   = ~sub;
    c = 0;
    while ((c <= 80) && !(done[0] && done[1] && done[2])) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!done[i]) begin
          if (ordy[i]) begin
            chk("valid_low_after_handshake", i, 64'(ov[i]), 64'd0);
            chk("ready_after_handshake", i, 64'(ir[i]), 64'd1);
            done[i] = 1'b1;
            ordy[i] = 1'b0;
          end else if (ov[i]) begin
            if (!seen[i]) begin
              seen[i] = 1'b1;
              chk("latency", i, 64'(c), 64'(nch(i)));
            end
            chk("sum", i, 64'(s_o[i]), 64'(es));
            chk("cout", i, 64'(co[i]), 64'(ec));
            chk("ready_low_in_done", i, 64'(ir[i]), 64'd0);
            if (stall[i] == 0) ordy[i] = 1'b1;
            else stall[i]--;
          end
        end
      end
      c++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("op_completed", i, 64'(done[i]), 64'd1);
      ordy[i] = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] es;
    logic        ec;
    bit          all_v;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    for (int i = 0; i < 3; i++) ordy[i] = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", i, 64'(ir[i]), 64'd1);
      chk("rst_out_valid", i, 64'(ov[i]), 64'd0);
      chk("rst_busy", i, 64'(bz[i]), 64'd0);
      chk("rst_out_s", i, 64'(s_o[i]), 64'd0);
      chk("rst_out_cout", i, 64'(co[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations: carry ripple across every slice, mixed carries, sub cases.
    do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1);
    do_op(32'd7, 32'd5, 1'b1, 0);
    do_op(32'd5, 32'd7, 1'b1, 2);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

    // Backpressure: hold results for five cycles while in_valid pulses.
    model(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, es, ec);
    @(negedge clk);
    in_a = 32'hDEAD_BEEF; in_b = 32'h0123_4567; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    all_v = 1'b0;
    for (int c = 0; (c < 40) && !all_v; c++) begin
      @(negedge clk);
      all_v = ov[0] && ov[1] && ov[2];
    end
    chk("bp_all_valid", 0, 64'(all_v), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("bp_valid_held", i, 64'(ov[i]), 64'd1);
        chk("bp_sum_held", i, 64'(s_o[i]), 64'(es));
        chk("bp_cout_held", i, 64'(co[i]), 64'(ec));
        chk("bp_in_ready_low", i, 64'(ir[i]), 64'd0);
        chk("bp_busy", i, 64'(bz[i]), 64'd1);
      end
      in_valid = (c % 2 == 0);
      in_a = $urandom; in_b = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) ordy[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_release_valid", i, 64'(ov[i]), 64'd0);
      chk("bp_release_ready", i, 64'(ir[i]), 64'd1);
      chk("bp_release_busy", i, 64'(bz[i]), 64'd0);
      chk("bp_sum_after_release", i, 64'(s_o[i]), 64'(es));
      ordy[i] = 1'b0;
    end

    // Reset while the CHUNK=8 instance is on slice index 2.
    @(negedge clk);
    in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 1, 64'(bz[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrun_rst_valid", i, 64'(ov[i]), 64'd0);
      chk("midrun_rst_sum", i, 64'(s_o[i]), 64'd0);
      chk("midrun_rst_cout", i, 64'(co[i]), 64'd0);
      chk("midrun_rst_busy", i, 64'(bz[i]), 64'd0);
      chk("midrun_rst_ready", i, 64'(ir[i]), 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'hCAFE_F00D, 32'h3501_0FF3, 1'b0, 1);

    // Random operations with random result stalls.
    for (int n = 0; n < 1000; n++) begin
      do_op($urandom, (n % 50 == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom), 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
